// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared types and constants for the fetch sequencer.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_unit_pkg;

  // Sequencer state: waiting for Start, executing, or halted by DNE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int INST_W = 9;

  // PUT r0 encoding; issued to the decoder whenever we are not running
  localparam logic [INST_W-1:0] NOP_INST = 9'h000;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_branch_resolve.sv
// ----------------------------------------------------------------------------
// branch_resolve
//   Combinational taken/not-taken decision from the decoder branch strobes
//   and the condition operand. Any qualifying strobe takes the branch.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module branch_resolve #(
  parameter int W = 8
) (
  input  logic         BranchEZ,
  input  logic         BranchNZ,
  input  logic         BranchAlways,
  input  logic [W-1:0] BrCond,
  output logic         take
);

  logic cond_zero;

  // Zero test covers every bit of the condition operand
  always_comb begin
    cond_zero = (BrCond == '0);
    take      = BranchAlways | (BranchEZ & cond_zero) | (BranchNZ & ~cond_zero);
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Program counter and start/run/halt fetch sequencer feeding the decoder.
//   Optional feature macro: FETCH_CYCLE_COUNT_EN enables the saturating
//   RUN-cycle counter on CycleCount; otherwise CycleCount is tied to zero.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int W = 8,
  parameter int T = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [T-1:0]      StartAddr,
  input  logic              Stall,
  output logic [T-1:0]      InstAddr,
  input  logic [INST_W-1:0] InstData,
  output logic [INST_W-1:0] Instruction,
  output logic [T-1:0]      ProgCtr_p1,
  input  logic              BranchEZ,
  input  logic              BranchNZ,
  input  logic              BranchAlways,
  input  logic              Done_in,
  input  logic [W-1:0]      BrTarget,
  input  logic [W-1:0]      BrCond,
  output logic              RunEn,
  output logic              Done,
  output logic [15:0]       CycleCount
);

  fetch_state_t state, state_next;
  logic [T-1:0] pc, pc_next;
  logic         take;

  branch_resolve #(.W(W)) u_branch_resolve (
    .BranchEZ     (BranchEZ),
    .BranchNZ     (BranchNZ),
    .BranchAlways (BranchAlways),
    .BrCond       (BrCond),
    .take         (take)
  );

  // State and PC registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Next state / next PC; Start beats stall, stall beats done, done beats branch
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      IDLE: begin
        if (Start) begin
          pc_next    = StartAddr;
          state_next = RUN;
        end
      end
      RUN: begin
        if (Start) begin
          pc_next = StartAddr;
        end else if (Stall) begin
          pc_next = pc;
        end else if (Done_in) begin
          state_next = HALT;
        end else if (take) begin
          pc_next = {{(T-W){1'b0}}, BrTarget};
        end else begin
          pc_next = ProgCtr_p1;
        end
      end
      HALT: begin
        if (Start) begin
          pc_next    = StartAddr;
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = '0;
      end
    endcase
  end

  // Datapath outputs derived from the registered PC and state
  always_comb begin
    InstAddr    = pc;
    ProgCtr_p1  = pc + 1'b1;
    Instruction = (state == RUN) ? InstData : NOP_INST;
    RunEn       = (state == RUN) && !Stall;
    Done        = (state == HALT);
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cycle_cnt;

  // Saturating RUN-cycle counter, stalled cycles included, cleared on Start
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cycle_cnt <= '0;
    end else if (Start) begin
      cycle_cnt <= '0;
    end else if ((state == RUN) && (cycle_cnt != 16'hFFFF)) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end

  assign CycleCount = cycle_cnt;
`else
  assign CycleCount = 16'h0000;
`endif

endmodule

`default_nettype wire
